// File: rtl/mips_pipe_pkg.sv
// Shared constants for the pipelined MIPS core: control bundle layout,
// forwarding select encodings, special register numbers and match helpers.
package mips_pipe_pkg;

    localparam int CTRL_W = 13;

    // Bit positions inside {RegWrite,MemtoReg,MemRead,MemWrite,BranchEQ,BranchNE,Jump,JAL,RegDst,ALUSrc,ALUOp[2:0]}
    localparam int CTRL_REGWRITE  = 12;
    localparam int CTRL_MEMTOREG  = 11;
    localparam int CTRL_MEMREAD   = 10;
    localparam int CTRL_MEMWRITE  = 9;
    localparam int CTRL_BRANCHEQ  = 8;
    localparam int CTRL_BRANCHNE  = 7;
    localparam int CTRL_JUMP      = 6;
    localparam int CTRL_JAL       = 5;
    localparam int CTRL_REGDST    = 4;
    localparam int CTRL_ALUSRC    = 3;
    localparam int CTRL_ALUOP_MSB = 2;
    localparam int CTRL_ALUOP_LSB = 0;

    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_MEMWB   = 2'b01;
    localparam logic [1:0] FWD_EXMEM   = 2'b10;

    localparam logic [4:0] REG_RA   = 5'd31;
    localparam logic [4:0] REG_ZERO = 5'd0;

    // True when a nonzero destination is read by either source.
    function automatic logic reg_match(input logic [4:0] dest,
                                       input logic [4:0] src_a,
                                       input logic [4:0] src_b);
        return (dest != REG_ZERO) && ((dest == src_a) || (dest == src_b));
    endfunction

    // EX/MEM wins over MEM/WB; $zero is never forwarded.
    function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                           input logic [4:0] mem_dest,
                                           input logic       mem_reg_write,
                                           input logic [4:0] wb_dest,
                                           input logic       wb_reg_write);
        if (mem_reg_write && (mem_dest != REG_ZERO) && (mem_dest == src))
            return FWD_EXMEM;
        else if (wb_reg_write && (wb_dest != REG_ZERO) && (wb_dest == src))
            return FWD_MEMWB;
        else
            return FWD_REGFILE;
    endfunction

endpackage

// File: rtl/id_ex_stage_hazard_unit.sv
// Combinational hazard unit: load-use stall, flush bubble and forwarding selects.
// Without FORWARD_EN the selects are tied off and RAW hazards stall instead.
module hazard_unit
    import mips_pipe_pkg::*;
(
    input  logic       reset,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       ex_valid,
    input  logic       ex_mem_read,
    input  logic       ex_reg_write,
    input  logic [4:0] ex_dest,
    input  logic [4:0] ex_rs,
    input  logic [4:0] ex_rt,
    input  logic [4:0] mem_dest,
    input  logic       mem_reg_write,
    input  logic [4:0] wb_dest,
    input  logic       wb_reg_write,
    input  logic       flush,
    output logic       stall,
    output logic       bubble,
    output logic       pc_write,
    output logic       if_id_write,
    output logic [1:0] fwd_a_sel,
    output logic [1:0] fwd_b_sel
);

    logic load_use;
    logic raw;

    assign load_use = ex_valid && ex_mem_read && reg_match(ex_dest, id_rs, id_rt);

`ifdef FORWARD_EN
    logic unused_fwd_build;
    assign unused_fwd_build = ex_reg_write;
    assign raw = 1'b0;

    always_comb begin
        fwd_a_sel = FWD_REGFILE;
        fwd_b_sel = FWD_REGFILE;
        if (ex_valid) begin
            fwd_a_sel = fwd_sel(ex_rs, mem_dest, mem_reg_write, wb_dest, wb_reg_write);
            fwd_b_sel = fwd_sel(ex_rt, mem_dest, mem_reg_write, wb_dest, wb_reg_write);
        end
    end
`else
    logic unused_fwd_build;
    assign unused_fwd_build = ^{ex_rs, ex_rt};

    // Operands wait in ID until every older producer has retired.
    assign raw = (ex_valid && ex_reg_write && reg_match(ex_dest, id_rs, id_rt))
              || (mem_reg_write && reg_match(mem_dest, id_rs, id_rt))
              || (wb_reg_write  && reg_match(wb_dest,  id_rs, id_rt));

    assign fwd_a_sel = FWD_REGFILE;
    assign fwd_b_sel = FWD_REGFILE;
`endif

    // No hazard can exist while reset is held, so the front end is never frozen then.
    assign stall       = reset && (load_use || raw);
    assign bubble      = stall || flush;
    assign pc_write    = !stall || flush;
    assign if_id_write = !stall || flush;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with hazard detection, flush bubbles and forwarding selects.
// Optional macro FORWARD_EN enables operand forwarding; otherwise RAW hazards stall.
module id_ex_stage
    import mips_pipe_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [DATA_W-1:0] id_pc4,
    input  logic [DATA_W-1:0] id_rd1,
    input  logic [DATA_W-1:0] id_rd2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [4:0]        id_rd,
    input  logic [4:0]        id_shamt,
    input  logic [5:0]        id_funct,
    input  logic              flush,
    input  logic [4:0]        mem_dest,
    input  logic [4:0]        wb_dest,
    input  logic              mem_reg_write,
    input  logic              wb_reg_write,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [DATA_W-1:0] ex_pc4,
    output logic [DATA_W-1:0] ex_rd1,
    output logic [DATA_W-1:0] ex_rd2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [4:0]        ex_rs,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_shamt,
    output logic [5:0]        ex_funct,
    output logic [4:0]        ex_dest,
    output logic              ex_valid,
    output logic              pc_write,
    output logic              if_id_write,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel
);

    logic       bubble;
    logic       unused_stall;
    logic [4:0] id_dest;

    assign id_dest = id_ctrl[CTRL_JAL]    ? REG_RA :
                     id_ctrl[CTRL_REGDST] ? id_rd  : id_rt;

    hazard_unit u_hazard (
        .reset        (reset),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .ex_valid     (ex_valid),
        .ex_mem_read  (ex_ctrl[CTRL_MEMREAD]),
        .ex_reg_write (ex_ctrl[CTRL_REGWRITE]),
        .ex_dest      (ex_dest),
        .ex_rs        (ex_rs),
        .ex_rt        (ex_rt),
        .mem_dest     (mem_dest),
        .mem_reg_write(mem_reg_write),
        .wb_dest      (wb_dest),
        .wb_reg_write (wb_reg_write),
        .flush        (flush),
        .stall        (unused_stall),
        .bubble       (bubble),
        .pc_write     (pc_write),
        .if_id_write  (if_id_write),
        .fwd_a_sel    (fwd_a_sel),
        .fwd_b_sel    (fwd_b_sel)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_ctrl  <= '0;
            ex_pc4   <= '0;
            ex_rd1   <= '0;
            ex_rd2   <= '0;
            ex_imm   <= '0;
            ex_rs    <= '0;
            ex_rt    <= '0;
            ex_shamt <= '0;
            ex_funct <= '0;
            ex_dest  <= '0;
            ex_valid <= 1'b0;
        end else if (bubble) begin
            // A bubble carries all-zero control, so it cannot write, store or redirect.
            ex_ctrl  <= '0;
            ex_pc4   <= '0;
            ex_rd1   <= '0;
            ex_rd2   <= '0;
            ex_imm   <= '0;
            ex_rs    <= '0;
            ex_rt    <= '0;
            ex_shamt <= '0;
            ex_funct <= '0;
            ex_dest  <= '0;
            ex_valid <= 1'b0;
        end else begin
            ex_ctrl  <= id_ctrl;
            ex_pc4   <= id_pc4;
            ex_rd1   <= id_rd1;
            ex_rd2   <= id_rd2;
            ex_imm   <= id_imm;
            ex_rs    <= id_rs;
            ex_rt    <= id_rt;
            ex_shamt <= id_shamt;
            ex_funct <= id_funct;
            ex_dest  <= id_dest;
            ex_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed scoreboard bench for id_ex_stage; expectations adapt to FORWARD_EN.
module tb_id_ex_stage;

    logic        clk;
    logic        reset;
    logic [12:0] id_ctrl;
    logic [31:0] id_pc4, id_rd1, id_rd2, id_imm;
    logic [4:0]  id_rs, id_rt, id_rd, id_shamt;
    logic [5:0]  id_funct;
    logic        flush;
    logic [4:0]  mem_dest, wb_dest;
    logic        mem_reg_write, wb_reg_write;
    logic [12:0] ex_ctrl;
    logic [31:0] ex_pc4, ex_rd1, ex_rd2, ex_imm;
    logic [4:0]  ex_rs, ex_rt, ex_shamt, ex_dest;
    logic [5:0]  ex_funct;
    logic        ex_valid, pc_write, if_id_write;
    logic [1:0]  fwd_a_sel, fwd_b_sel;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [12:0] C_ORI = 13'h1008;
    localparam logic [12:0] C_LW  = 13'h1C08;
    localparam logic [12:0] C_ADD = 13'h1012;
    localparam logic [12:0] C_JAL = 13'h1060;

`ifdef FORWARD_EN
    localparam logic [1:0] F_EXMEM = 2'b10;
    localparam logic [1:0] F_MEMWB = 2'b01;
`else
    localparam logic [1:0] F_EXMEM = 2'b00;
    localparam logic [1:0] F_MEMWB = 2'b00;
`endif

    typedef struct {
        logic [12:0] ctrl;
        logic [31:0] pc4, rd1, rd2, imm;
        logic [4:0]  rs, rt, shamt, dest;
        logic [5:0]  funct;
        logic        valid;
    } ex_t;

    ex_t sb[$];

    id_ex_stage dut (
        .clk(clk), .reset(reset), .id_ctrl(id_ctrl), .id_pc4(id_pc4),
        .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm), .id_rs(id_rs),
        .id_rt(id_rt), .id_rd(id_rd), .id_shamt(id_shamt), .id_funct(id_funct),
        .flush(flush), .mem_dest(mem_dest), .wb_dest(wb_dest),
        .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
        .ex_ctrl(ex_ctrl), .ex_pc4(ex_pc4), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2),
        .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_shamt(ex_shamt),
        .ex_funct(ex_funct), .ex_dest(ex_dest), .ex_valid(ex_valid),
        .pc_write(pc_write), .if_id_write(if_id_write),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [12:0] c, input logic [31:0] pc4, input logic [31:0] rd1,
                         input logic [31:0] rd2, input logic [31:0] imm, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
                         input logic [5:0] fn);
        id_ctrl = c; id_pc4 = pc4; id_rd1 = rd1; id_rd2 = rd2; id_imm = imm;
        id_rs = rs; id_rt = rt; id_rd = rd; id_shamt = sh; id_funct = fn;
    endtask

    task automatic push_capture();
        ex_t e;
        e.ctrl = id_ctrl; e.pc4 = id_pc4; e.rd1 = id_rd1; e.rd2 = id_rd2; e.imm = id_imm;
        e.rs = id_rs; e.rt = id_rt; e.shamt = id_shamt; e.funct = id_funct;
        e.dest = id_ctrl[5] ? 5'd31 : (id_ctrl[4] ? id_rd : id_rt);
        e.valid = 1'b1;
        sb.push_back(e);
    endtask

    task automatic push_bubble();
        ex_t e;
        e.ctrl = '0; e.pc4 = '0; e.rd1 = '0; e.rd2 = '0; e.imm = '0;
        e.rs = '0; e.rt = '0; e.shamt = '0; e.funct = '0; e.dest = '0; e.valid = 1'b0;
        sb.push_back(e);
    endtask

    task automatic step(input string tag);
        ex_t e;
        @(posedge clk);
        #1;
        chk({tag, "_sb_depth"}, sb.size(), 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_ctrl"},  ex_ctrl,  e.ctrl);
            chk({tag, "_pc4"},   ex_pc4,   e.pc4);
            chk({tag, "_rd1"},   ex_rd1,   e.rd1);
            chk({tag, "_rd2"},   ex_rd2,   e.rd2);
            chk({tag, "_imm"},   ex_imm,   e.imm);
            chk({tag, "_rs"},    ex_rs,    e.rs);
            chk({tag, "_rt"},    ex_rt,    e.rt);
            chk({tag, "_shamt"}, ex_shamt, e.shamt);
            chk({tag, "_funct"}, ex_funct, e.funct);
            chk({tag, "_dest"},  ex_dest,  e.dest);
            chk({tag, "_valid"}, ex_valid, e.valid);
        end
    endtask

    task automatic hz(input string tag, input logic pw, input logic iw,
                      input logic [1:0] fa, input logic [1:0] fb);
        #1;
        chk({tag, "_pc_write"},    pc_write,    pw);
        chk({tag, "_if_id_write"}, if_id_write, iw);
        chk({tag, "_fwd_a"},       fwd_a_sel,   fa);
        chk({tag, "_fwd_b"},       fwd_b_sel,   fb);
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0;
        mem_dest = '0; wb_dest = '0; mem_reg_write = 1'b0; wb_reg_write = 1'b0;
        drive(C_ORI, 32'h4, 32'h11, 32'h22, 32'h7, 5'd0, 5'd10, 5'd0, 5'd0, 6'd0);

        // reset state and release
        #2;
        chk("rst_valid", ex_valid, 1'b0);
        chk("rst_ctrl", ex_ctrl, 13'h0);
        chk("rst_rd1", ex_rd1, 32'h0);
        hz("rst", 1'b1, 1'b1, 2'b00, 2'b00);
        @(posedge clk);
        #1;
        chk("rst_hold_valid", ex_valid, 1'b0);
        reset = 1'b1;
        push_capture();
        step("rst_first");
        #1 reset = 1'b0;
        #1;
        chk("rst_async_valid", ex_valid, 1'b0);
        chk("rst_async_rd1", ex_rd1, 32'h0);
        chk("rst_async_dest", ex_dest, 5'd0);
        chk("rst_async_pcw", pc_write, 1'b1);
        reset = 1'b1;

        // pass-through addi
        drive(C_ORI, 32'h8, 32'h5, 32'h33, 32'hFFFF_FFFC, 5'd2, 5'd9, 5'd3, 5'd0, 6'd0);
        hz("addi", 1'b1, 1'b1, 2'b00, 2'b00);
        push_capture();
        step("addi");

        // load-use: one stall, bubble, then the add enters
        drive(C_LW, 32'hC, 32'h100, 32'h0, 32'h4, 5'd2, 5'd8, 5'd0, 5'd0, 6'd0);
        hz("lw", 1'b1, 1'b1, 2'b00, 2'b00);
        push_capture();
        step("lw");
        drive(C_ADD, 32'h10, 32'h44, 32'h55, 32'h5820, 5'd8, 5'd3, 5'd11, 5'd0, 6'h20);
        hz("lu_stall", 1'b0, 1'b0, 2'b00, 2'b00);
        push_bubble();
        step("lu_bubble");
        hz("lu_release", 1'b1, 1'b1, 2'b00, 2'b00);
        push_capture();
        step("lu_add");

        // forwarding priority
        drive(C_ADD, 32'h14, 32'h1, 32'h2, 32'h0, 5'd9, 5'd3, 5'd12, 5'd0, 6'h20);
        hz("fwd_load", 1'b1, 1'b1, 2'b00, 2'b00);
        push_capture();
        step("fwd_inst");
        drive(13'h0, 32'h18, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0);
        mem_dest = 5'd9; mem_reg_write = 1'b1; wb_dest = 5'd9; wb_reg_write = 1'b1;
        hz("fwd_both", 1'b1, 1'b1, F_EXMEM, 2'b00);
        mem_reg_write = 1'b0;
        hz("fwd_wb", 1'b1, 1'b1, F_MEMWB, 2'b00);
        mem_dest = 5'd3; mem_reg_write = 1'b1;
        hz("fwd_split", 1'b1, 1'b1, F_MEMWB, F_EXMEM);
        mem_dest = 5'd0; wb_dest = 5'd0;
        push_capture();
        step("fwd_nop");
        hz("fwd_zero", 1'b1, 1'b1, 2'b00, 2'b00);
        mem_reg_write = 1'b0; wb_reg_write = 1'b0;

        // flush and load-use together
        drive(C_LW, 32'h1C, 32'h200, 32'h0, 32'h8, 5'd2, 5'd8, 5'd0, 5'd0, 6'd0);
        push_capture();
        step("lw2");
        drive(C_ADD, 32'h20, 32'h66, 32'h67, 32'h0, 5'd8, 5'd3, 5'd11, 5'd0, 6'h20);
        flush = 1'b1;
        hz("flush_stall", 1'b1, 1'b1, 2'b00, 2'b00);
        push_bubble();
        step("flush_bubble");
        flush = 1'b0;
        hz("flush_after", 1'b1, 1'b1, 2'b00, 2'b00);

        // reset during a stall drops it immediately
        drive(C_LW, 32'h24, 32'h300, 32'h0, 32'hC, 5'd2, 5'd8, 5'd0, 5'd0, 6'd0);
        push_capture();
        step("lw3");
        drive(C_ADD, 32'h28, 32'h68, 32'h69, 32'h0, 5'd8, 5'd3, 5'd11, 5'd0, 6'h20);
        #1;
        chk("mid_stall_pcw", pc_write, 1'b0);
        reset = 1'b0;
        #1;
        chk("mid_rst_pcw", pc_write, 1'b1);
        chk("mid_rst_ifid", if_id_write, 1'b1);
        chk("mid_rst_valid", ex_valid, 1'b0);
        #1 reset = 1'b1;
        push_capture();
        step("post_rst_add");

        // JAL destination and RAW behaviour behind it
        drive(C_JAL, 32'h2C, 32'h77, 32'h88, 32'h10, 5'd0, 5'd4, 5'd7, 5'd0, 6'd0);
        hz("jal_in", 1'b1, 1'b1, 2'b00, 2'b00);
        push_capture();
        step("jal");
        drive(C_ADD, 32'h30, 32'h9, 32'hA, 32'h0, 5'd31, 5'd2, 5'd13, 5'd0, 6'h20);
`ifdef FORWARD_EN
        hz("jal_dep", 1'b1, 1'b1, 2'b00, 2'b00);
        push_capture();
        step("jal_dep_add");
        mem_dest = 5'd31; mem_reg_write = 1'b1;
        hz("jal_fwd", 1'b1, 1'b1, 2'b10, 2'b00);
        mem_reg_write = 1'b0;
`else
        hz("raw_ex", 1'b0, 1'b0, 2'b00, 2'b00);
        push_bubble();
        step("raw_b1");
        mem_dest = 5'd31; mem_reg_write = 1'b1;
        hz("raw_mem", 1'b0, 1'b0, 2'b00, 2'b00);
        push_bubble();
        step("raw_b2");
        mem_reg_write = 1'b0; wb_dest = 5'd31; wb_reg_write = 1'b1;
        hz("raw_wb", 1'b0, 1'b0, 2'b00, 2'b00);
        push_bubble();
        step("raw_b3");
        wb_reg_write = 1'b0;
        hz("raw_clear", 1'b1, 1'b1, 2'b00, 2'b00);
        push_capture();
        step("raw_add");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
